rx_interface: RTL
=================

RX_INTERFACE -- requirements
Module: rx_interface

Interface
REQ-001 Parameter META_FRAME_LEN, default 16, words per metaframe including sync and scrambler-state words.
REQ-002 Parameter LOCK_CNT, default 4, consecutive correctly spaced sync words needed to declare lock.
REQ-003 Parameter UNLOCK_CNT, default 3, consecutive missing or corrupt sync words needed to drop lock.
REQ-004 USER_CLK  in  1  the single clock; all state changes on its rising edge.
REQ-005 SYSTEM_RESET_N  in  1  reset, asynchronous assert, active-low.
REQ-006 DATA_IN  in  64  received block payload from the gearbox.
REQ-007 HEADER_IN  in  2  received block sync header.
REQ-008 DATA_VALID_IN  in  1  DATA_IN/HEADER_IN carry a new block this cycle; gaps are legal.
REQ-009 DATA_OUT  out  64  payload word, registered.
REQ-010 DATA_OUT_VALID  out  1  DATA_OUT holds a payload word this cycle (one-cycle pulse per word).
REQ-011 LOCKED  out  1  metaframe lock achieved.
REQ-012 SYNC_ERR  out  1  one-cycle pulse when lock is lost.
REQ-013 HEADER_ERR  out  1  one-cycle pulse on an illegal header/control block while locked.
REQ-014 CTRL_ERR  out  1  one-cycle pulse on a bad scrambler-state word while locked.
REQ-015 ERR_COUNT  out  16  saturating count of all error events while locked.

Function
REQ-016 Sync word = header 2'b10 with DATA_IN 64'h78F678F678F678F6; scrambler-state word = header 2'b10 with DATA_IN[63:58] 6'b001010; idle = header 2'b10 with DATA_IN 64'hAAAAAAAAAAAAAAAA; data = header 2'b01.
REQ-017 Frame position counter, width clog2(META_FRAME_LEN), advances only on DATA_VALID_IN; wraps META_FRAME_LEN-1 -> 0; holds during gaps.
REQ-018 States HUNT, VERIFY, LOCK; reset state HUNT.
REQ-019 HUNT: valid sync word -> position 1, good count 1, go VERIFY; any other word ignored.
REQ-020 VERIFY: at position 0, sync match -> good count +1; when good count reaches LOCK_CNT -> LOCK; mismatch -> HUNT, good count 0; no error pulses or ERR_COUNT changes in VERIFY.
REQ-021 LOCK: at position 0, sync match -> bad count 0; mismatch -> bad count +1, ERR_COUNT +1; when bad count reaches UNLOCK_CNT -> HUNT, SYNC_ERR pulse, LOCKED low next cycle.
REQ-022 LOCKED high from the cycle after the LOCK_CNT-th accepted sync word until the cycle after the transition to HUNT.
REQ-023 LOCK, position 1: word not a scrambler-state word -> CTRL_ERR pulse, ERR_COUNT +1, no state change.
REQ-024 LOCK, positions 2..META_FRAME_LEN-1: data word -> DATA_OUT = DATA_IN and DATA_OUT_VALID high the next cycle (latency 1); idle dropped silently; header 2'b00/2'b11 or other 2'b10 content -> HEADER_ERR pulse, ERR_COUNT +1, word dropped.
REQ-025 DATA_OUT_VALID never asserts outside LOCK; DATA_OUT holds its last value when not valid.
REQ-026 ERR_COUNT saturates at 16'hFFFF; at most one increment per cycle; cleared only by reset.
REQ-027 Error pulses are registered, aligned with the cycle DATA_OUT_VALID would have used (latency 1).

Reset
REQ-028 SYSTEM_RESET_N low asynchronously forces DATA_OUT 0, all valid/pulse outputs 0, LOCKED 0, ERR_COUNT 0, position 0, good/bad counts 0, state HUNT, including mid-metaframe.
REQ-029 After release, first DATA_VALID_IN word is evaluated in HUNT.

Structure
REQ-030 Sync word, idle word, scrambler-state block type, header codes and META_FRAME_LEN default live in a shared constants file also used by tx_interface.
REQ-031 Combinational block classifier (sync/scram/idle/data/illegal) is one sub-module, rx_word_classify; framing FSM and datapath stay in rx_interface.

Verification
REQ-032 Reset, then 4 well-formed metaframes with data words 64'h0000000000000000+n -> LOCKED high cycle after 4th sync; frame-4 data words appear on DATA_OUT one cycle after input, 14 pulses.
REQ-033 Locked stream, 3 consecutive corrupt sync words (64'h78F678F678F678F7) -> SYNC_ERR pulse after 3rd, LOCKED low, ERR_COUNT 3, no further DATA_OUT_VALID.
REQ-034 Locked stream, 2 corrupt syncs then good sync -> LOCKED stays high, ERR_COUNT 2, data continues.
REQ-035 Locked stream, idle words at positions 2-15 -> no DATA_OUT_VALID; header 2'b11 at position 5 -> HEADER_ERR pulse, ERR_COUNT +1.
REQ-036 Locked stream with DATA_VALID_IN low every 3rd cycle -> position holds, lock kept, output order preserved.
REQ-037 SYSTEM_RESET_N pulsed low mid-metaframe -> all outputs 0 immediately; relock needs 4 fresh syncs.

Source files
------------

// File: rtl/rx_interface_pkg.sv
// Block-level constants shared by the receive and transmit sides of the metaframe link.
// Also holds the word-class and framing-state enums used by the receiver.
package rx_interface_pkg;

    localparam int          META_FRAME_LEN_DEF = 16;
    localparam logic [1:0]  HDR_DATA           = 2'b01;
    localparam logic [1:0]  HDR_CTRL           = 2'b10;
    localparam logic [63:0] SYNC_WORD          = 64'h78F678F678F678F6;
    localparam logic [63:0] IDLE_WORD          = 64'hAAAAAAAAAAAAAAAA;
    localparam logic [5:0]  SCRAM_BTYPE        = 6'b001010;

    typedef enum logic [2:0] {
        WC_SYNC,
        WC_SCRAM,
        WC_IDLE,
        WC_DATA,
        WC_ILLEGAL
    } word_class_e;

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_VERIFY,
        ST_LOCK
    } rx_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/rx_word_classify.sv
// Combinational classifier: maps one received block (header + payload) to its word class.
module rx_word_classify
    import rx_interface_pkg::*;
(
    input  logic [1:0]  header_i,
    input  logic [63:0] data_i,
    output word_class_e class_o
);

    always_comb begin
        class_o = WC_ILLEGAL;
        if (header_i == HDR_DATA) begin
            class_o = WC_DATA;
        end else if (header_i == HDR_CTRL) begin
            if (data_i == SYNC_WORD) begin
                class_o = WC_SYNC;
            end else if (data_i == IDLE_WORD) begin
                class_o = WC_IDLE;
            end else if (data_i[63:58] == SCRAM_BTYPE) begin
                class_o = WC_SCRAM;
            end
        end
    end

endmodule

// File: rtl/rx_interface.sv
// Metaframe receiver: hunts for sync words, verifies their spacing, then forwards
// payload words and flags framing errors while locked.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_HUNT   | searching every valid word for a sync word
// ST_VERIFY | sync seen; counting correctly spaced syncs toward lock
// ST_LOCK   | locked; forwarding data, counting missing syncs toward loss
module rx_interface
    import rx_interface_pkg::*;
#(
    parameter int META_FRAME_LEN = META_FRAME_LEN_DEF,
    parameter int LOCK_CNT       = 4,
    parameter int UNLOCK_CNT     = 3
) (
    input  logic        USER_CLK,
    input  logic        SYSTEM_RESET_N,
    input  logic [63:0] DATA_IN,
    input  logic [1:0]  HEADER_IN,
    input  logic        DATA_VALID_IN,
    output logic [63:0] DATA_OUT,
    output logic        DATA_OUT_VALID,
    output logic        LOCKED,
    output logic        SYNC_ERR,
    output logic        HEADER_ERR,
    output logic        CTRL_ERR,
    output logic [15:0] ERR_COUNT
);

    localparam int POS_W  = (META_FRAME_LEN > 1) ? $clog2(META_FRAME_LEN) : 1;
    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int BAD_W  = $clog2(UNLOCK_CNT + 1);

    localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(META_FRAME_LEN - 1);
    localparam logic [POS_W-1:0]  POS_SCRAM = POS_W'(1);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT - 1);
    localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(UNLOCK_CNT - 1);

    word_class_e       word_class;
    rx_state_e         state_q, state_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic [GOOD_W-1:0] good_q, good_d;
    logic [BAD_W-1:0]  bad_q, bad_d;
    logic [63:0]       data_out_q, data_out_d;
    logic              valid_q, valid_d;
    logic              sync_err_q, sync_err_d;
    logic              hdr_err_q, hdr_err_d;
    logic              ctrl_err_q, ctrl_err_d;
    logic [15:0]       err_cnt_q, err_cnt_d;
    logic              err_event;

    rx_word_classify u_classify (
        .header_i (HEADER_IN),
        .data_i   (DATA_IN),
        .class_o  (word_class)
    );

    always_comb begin
        state_d    = state_q;
        pos_d      = pos_q;
        good_d     = good_q;
        bad_d      = bad_q;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        sync_err_d = 1'b0;
        hdr_err_d  = 1'b0;
        ctrl_err_d = 1'b0;
        err_event  = 1'b0;

        if (DATA_VALID_IN) begin
            pos_d = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
            unique case (state_q)
                ST_HUNT: begin
                    if (word_class == WC_SYNC) begin
                        pos_d   = POS_SCRAM;
                        good_d  = GOOD_W'(1);
                        bad_d   = '0;
                        state_d = (LOCK_CNT <= 1) ? ST_LOCK : ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    if (pos_q == '0) begin
                        if (word_class == WC_SYNC) begin
                            good_d = good_q + 1'b1;
                            if (good_q == GOOD_LAST) begin
                                state_d = ST_LOCK;
                                bad_d   = '0;
                            end
                        end else begin
                            state_d = ST_HUNT;
                            good_d  = '0;
                        end
                    end
                end
                ST_LOCK: begin
                    if (pos_q == '0) begin
                        if (word_class == WC_SYNC) begin
                            bad_d = '0;
                        end else begin
                            err_event = 1'b1;
                            bad_d     = bad_q + 1'b1;
                            if (bad_q == BAD_LAST) begin
                                state_d    = ST_HUNT;
                                sync_err_d = 1'b1;
                                good_d     = '0;
                                bad_d      = '0;
                            end
                        end
                    end else if (pos_q == POS_SCRAM) begin
                        if (word_class != WC_SCRAM) begin
                            ctrl_err_d = 1'b1;
                            err_event  = 1'b1;
                        end
                    end else if (word_class == WC_DATA) begin
                        data_out_d = DATA_IN;
                        valid_d    = 1'b1;
                    end else if (word_class != WC_IDLE) begin
                        // sync or scrambler words out of place are treated as illegal here
                        hdr_err_d = 1'b1;
                        err_event = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                end
            endcase
        end

        err_cnt_d = err_event ? sat_inc16(err_cnt_q) : err_cnt_q;
    end

    always_ff @(posedge USER_CLK or negedge SYSTEM_RESET_N) begin
        if (!SYSTEM_RESET_N) begin
            state_q    <= ST_HUNT;
            pos_q      <= '0;
            good_q     <= '0;
            bad_q      <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            sync_err_q <= 1'b0;
            hdr_err_q  <= 1'b0;
            ctrl_err_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            pos_q      <= pos_d;
            good_q     <= good_d;
            bad_q      <= bad_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            sync_err_q <= sync_err_d;
            hdr_err_q  <= hdr_err_d;
            ctrl_err_q <= ctrl_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign DATA_OUT       = data_out_q;
    assign DATA_OUT_VALID = valid_q;
    assign LOCKED         = (state_q == ST_LOCK);
    assign SYNC_ERR       = sync_err_q;
    assign HEADER_ERR     = hdr_err_q;
    assign CTRL_ERR       = ctrl_err_q;
    assign ERR_COUNT      = err_cnt_q;

endmodule
